// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out shift register.
package piso_pkg;

  // Controller states; PARITY is only reachable when PISO_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  // Bit-index counter width for a word of the given width (width >= 2).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: synchronous clear, count enable,
// wraps to zero after the last position and flags the last position.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count;

  assign tc = (count == LAST);

  // Clear has priority; wrapping at the last position keeps the counter at zero between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with valid/ready load, stall and
// back-to-back framing. Optional even parity bit: define PISO_PARITY_EN.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             stall,
  output logic             o,
  output logic             o_valid,
  output logic             o_last
);

  piso_state_t      state;
  piso_state_t      state_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic             head;
  logic             tc;
  logic             accept;
  logic             advance;

`ifdef PISO_PARITY_EN
  logic             parity;
`endif

  // Bit order only changes which end of the register is the head and which way it moves.
  generate
    if (MSB_FIRST) begin : g_msb
      assign head       = sr[WIDTH-1];
      assign sr_shifted = {sr[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head       = sr[0];
      assign sr_shifted = {1'b0, sr[WIDTH-1:1]};
    end
  endgenerate

  // A new word can enter when idle or on the final bit of a frame, never while stalled.
  assign load_ready = ((state == IDLE) || o_last) && !stall;
  assign accept     = load_valid && load_ready;
  assign advance    = (state == SHIFT) && !stall;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (advance),
    .tc  (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a stall freezes the controller.
  always_comb begin
    state_next = state;
    if (!stall) begin
      case (state)
        IDLE: begin
          if (accept) state_next = SHIFT;
        end
        SHIFT: begin
          if (tc) begin
`ifdef PISO_PARITY_EN
            state_next = PARITY;
`else
            state_next = accept ? SHIFT : IDLE;
`endif
          end
        end
        PARITY: begin
          state_next = accept ? SHIFT : IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode from the registered state, so a stall holds the outputs too.
  always_comb begin
    o       = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    case (state)
      SHIFT: begin
        o       = head;
        o_valid = 1'b1;
`ifndef PISO_PARITY_EN
        o_last  = tc;
`endif
      end
      PARITY: begin
`ifdef PISO_PARITY_EN
        o       = parity;
        o_valid = 1'b1;
        o_last  = 1'b1;
`endif
      end
      default: begin
        o       = 1'b0;
        o_valid = 1'b0;
        o_last  = 1'b0;
      end
    endcase
  end

  // Shift register: capture on accept, move one place per unstalled data cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (accept) begin
      sr <= din;
    end else if (advance) begin
      sr <= sr_shifted;
    end
  end

`ifdef PISO_PARITY_EN
  // Even parity of the captured word, fixed for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^din;
    end
  end
`endif

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench: two instances (MSB-first and LSB-first) share stimulus
// and are compared each cycle against a queue-of-frame-bits reference model.
module tb_piso_shift_reg;

  localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             stall = 1'b0;

  logic m_ready, m_o, m_valid, m_last;
  logic l_ready, l_o, l_valid, l_last;

  int n_assert = 0;
  int n_fail   = 0;

  // Remaining bits of the frame currently on the line, per bit order.
  bit q_m[$];
  bit q_l[$];

  logic obs_m, obs_l;
  logic [3:0] seq_m, seq_l;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_ready),
    .din(din), .stall(stall), .o(m_o), .o_valid(m_valid), .o_last(m_last)
  );

  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_ready),
    .din(din), .stall(stall), .o(l_o), .o_valid(l_valid), .o_last(l_last)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Build the expected serial frames for a word.
  task automatic load_model(input logic [WIDTH-1:0] d);
    q_m.delete();
    q_l.delete();
    for (int i = WIDTH - 1; i >= 0; i--) q_m.push_back(d[i]);
    for (int i = 0; i < WIDTH; i++) q_l.push_back(d[i]);
`ifdef PISO_PARITY_EN
    q_m.push_back(^d);
    q_l.push_back(^d);
`endif
  endtask

  task automatic check_outputs(input logic st);
    logic exp_ready;
    exp_ready = (q_m.size() <= 1) && !st;
    chk("m_o",     m_o,     (q_m.size() > 0) ? q_m[0] : 1'b0);
    chk("m_valid", m_valid, q_m.size() > 0);
    chk("m_last",  m_last,  q_m.size() == 1);
    chk("m_ready", m_ready, exp_ready);
    chk("l_o",     l_o,     (q_l.size() > 0) ? q_l[0] : 1'b0);
    chk("l_valid", l_valid, q_l.size() > 0);
    chk("l_last",  l_last,  q_l.size() == 1);
    chk("l_ready", l_ready, exp_ready);
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic lv, input logic [WIDTH-1:0] d, input logic st);
    bit acc;
    @(negedge clk);
    load_valid = lv;
    din        = d;
    stall      = st;
    #1;
    check_outputs(st);
    obs_m = m_o;
    obs_l = l_o;
    $display("t=%0t lv=%b din=%b stall=%b | m: o=%b v=%b l=%b r=%b | l: o=%b v=%b l=%b r=%b",
             $time, lv, d, st, m_o, m_valid, m_last, m_ready, l_o, l_valid, l_last, l_ready);
    acc = lv && !st && (q_m.size() <= 1);
    @(posedge clk);
    if (!st) begin
      if (acc) begin
        load_model(d);
      end else if (q_m.size() > 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
    end
  endtask

  initial begin
    // Reset state while rst is held low.
    #2;
    chk("rst_m_o",     m_o,     1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last",  m_last,  1'b0);
    chk("rst_m_ready", m_ready, 1'b1);
    chk("rst_l_ready", l_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Single word 1011: MSB-first 1,0,1,1 and LSB-first 1,1,0,1.
    step(1'b1, 4'b1011, 1'b0);
    seq_m = '0;
    seq_l = '0;
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b0, 4'b0000, 1'b0);
      seq_m = {seq_m[2:0], obs_m};
      seq_l = {seq_l[2:0], obs_l};
    end
    chk("seq_m_bit0", seq_m[3], 1'b1);
    n_assert++;
    assert (seq_m === 4'b1011) else begin
      n_fail++;
      $error("FAIL seq_m: observed %b expected %b", seq_m, 4'b1011);
    end
    n_assert++;
    assert (seq_l === 4'b1101) else begin
      n_fail++;
      $error("FAIL seq_l: observed %b expected %b", seq_l, 4'b1101);
    end
    for (int i = WIDTH; i < FLEN + 2; i++) step(1'b0, 4'b0000, 1'b0);

    // Back-to-back: second word loaded on the o_last cycle of the first.
    step(1'b1, 4'b1011, 1'b0);
    for (int i = 0; i < FLEN - 1; i++) step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0110, 1'b0);
    for (int i = 0; i < FLEN + 1; i++) step(1'b0, 4'b0000, 1'b0);

    // Stall for two cycles after the second bit of 1100, with load_valid held to test refusal.
    step(1'b1, 4'b1100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0101, 1'b1);
    step(1'b1, 4'b0101, 1'b1);
    for (int i = 0; i < FLEN; i++) step(1'b0, 4'b0000, 1'b0);

    // Asynchronous reset mid-frame, then a fresh word.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_m_o",     m_o,     1'b0);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_m_last",  m_last,  1'b0);
    chk("mid_rst_l_valid", l_valid, 1'b0);
    chk("mid_rst_m_ready", m_ready, 1'b1);
    q_m.delete();
    q_l.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 4'b0001, 1'b0);
    for (int i = 0; i < FLEN + 1; i++) step(1'b0, 4'b0000, 1'b0);

`ifdef PISO_PARITY_EN
    // Parity-zero word.
    step(1'b1, 4'b1001, 1'b0);
    for (int i = 0; i < FLEN + 1; i++) step(1'b0, 4'b0000, 1'b0);
`endif

    // Randomized traffic with occasional stalls.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < FLEN + 2; i++) step(1'b0, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
